// File: rtl/pulse_meter_if.sv
// Bus bundle for pulse_meter: measured signal, arm request, status strobes and results.
// The master drives sig_in/start; the slave (the meter) drives everything else.
interface pulse_meter_if #(
   parameter int CNT_W = 16
);
   logic             sig_in;
   logic             start;
   logic             busy;
   logic             valid;
   logic             err;
   logic [CNT_W-1:0] high_cnt;
   logic [CNT_W-1:0] low_cnt;
   logic [CNT_W:0]   period;

   modport master (
      output sig_in, start,
      input  busy, valid, err, high_cnt, low_cnt, period
   );

   modport slave (
      input  sig_in, start,
      output busy, valid, err, high_cnt, low_cnt, period
   );
endinterface

// File: rtl/pulse_meter.sv
// Measures high width, low width and period of an asynchronous signal in clk_in cycles.
// Define PULSE_METER_CONT_EN for continuous back-to-back measurement after one start.
module pulse_meter #(
   parameter int CNT_W = 16
) (
   input  logic          clk_in,
   input  logic          rst_n,
   pulse_meter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic             sync1_q, sync2_q, hist_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic [CNT_W-1:0] low_q, low_d;
   logic [CNT_W:0]   period_q, period_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic             rise, fall;

   assign rise = sync2_q & ~hist_q;
   assign fall = ~sync2_q & hist_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hold_d   = hold_q;
      high_d   = high_q;
      low_d    = low_q;
      period_d = period_q;
      busy_d   = busy_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = ARM;
               busy_d  = 1'b1;
            end
         end
         ARM: begin
            // Only a fresh rising edge starts a measurement; a level already high is skipped.
            if (rise) begin
               cnt_d   = CNT_ONE;
               state_d = HIGH;
            end
         end
         HIGH: begin
            if (fall) begin
               hold_d  = cnt_q;
               cnt_d   = CNT_ONE;
               state_d = LOW;
            end else if (cnt_q == CNT_MAX) begin
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         LOW: begin
            if (rise) begin
               high_d   = hold_q;
               low_d    = cnt_q;
               period_d = {1'b0, hold_q} + {1'b0, cnt_q};
               valid_d  = 1'b1;
`ifdef PULSE_METER_CONT_EN
               // The terminating edge doubles as t0 of the next measurement.
               cnt_d    = CNT_ONE;
               state_d  = HIGH;
`else
               busy_d   = 1'b0;
               state_d  = IDLE;
`endif
            end else if (cnt_q == CNT_MAX) begin
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         hist_q   <= 1'b0;
         cnt_q    <= '0;
         hold_q   <= '0;
         high_q   <= '0;
         low_q    <= '0;
         period_q <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync1_q  <= bus.sig_in;
         sync2_q  <= sync1_q;
         hist_q   <= sync2_q;
         cnt_q    <= cnt_d;
         hold_q   <= hold_d;
         high_q   <= high_d;
         low_q    <= low_d;
         period_q <= period_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.valid    = valid_q;
   assign bus.err      = err_q;
   assign bus.high_cnt = high_q;
   assign bus.low_cnt  = low_q;
   assign bus.period   = period_q;
endmodule

// File: doc/pulse_meter.md
# pulse_meter

Measures the waveform produced by the clock-divider blocks. An asynchronous digital signal is synchronised into the `clk_in` domain, and the block counts its high width, low width and period in `clk_in` cycles. Each completed measurement is reported with a one-cycle `valid` strobe. It sits on the receive side of a divided-clock output and is used to check divider ratios and duty cycle in-system.

## Interface
- `CNT_W`, default 16: width of the width/period counters and result outputs.
- `clk_in`  input  1  system clock; all logic on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `sig_in`  input  1  measured signal; asynchronous to `clk_in`.
- `start`  input  1  single-cycle request to arm a measurement.
- `busy`  output  1  high from accepted `start` until done or error.
- `valid`  output  1  one-cycle strobe: result outputs updated.
- `err`  output  1  one-cycle strobe: measurement aborted on counter overflow.
- `high_cnt`  output  CNT_W  cycles `sig_in` was high.
- `low_cnt`  output  CNT_W  cycles `sig_in` was low.
- `period`  output  CNT_W+1  `high_cnt + low_cnt`.

## Operation
- **Input conditioning**
  - `sig_in` passes through a 2-flop synchroniser, then a history flop.
  - `rise` = synchronised level is 1 and history is 0.
  - `fall` = synchronised level is 0 and history is 1.
- **FSM states:** IDLE, ARM, HIGH, LOW.
- **Transitions**
  - IDLE: `start` moves to ARM and sets `busy`. `start` in any other state is ignored.
  - ARM: wait for `rise`. A level already high at arm time is not counted; the block waits for a fresh rising edge. On `rise`, clear `cnt` to 1 and go to HIGH.
  - HIGH: increment `cnt` each cycle. On `fall`, latch `cnt` into a high holding register, reload `cnt` to 1 and go to LOW.
  - LOW: increment `cnt` each cycle. On `rise`, do all of the following in the same clock:
    - load `high_cnt` from the holding register;
    - load `low_cnt` from `cnt`;
    - load `period` as the CNT_W+1-bit sum;
    - assert `valid` and go to IDLE, clearing `busy`.
- **Resulting counts**
  - `rise` at cycle t0, `fall` at t1, `rise` at t2.
  - `high_cnt = t1-t0`, `low_cnt = t2-t1`, `period = t2-t0`.
- **Overflow**
  - In HIGH or LOW, if `cnt` equals all-ones and the ending edge has not arrived, pulse `err` for one cycle and go to IDLE.
  - `busy` clears; result outputs keep their previous values; `valid` does not fire.
- **Hold behaviour:** results hold until the next `valid`.
- **Reset:** `rst_n` low at any time forces, asynchronously:
  - IDLE, with synchroniser and history flops at 0;
  - `busy`, `valid` and `err` at 0;
  - `high_cnt`, `low_cnt` and `period` at 0.

## Timing
- **Edge-detect latency:** a `sig_in` edge set up before clock k produces `rise`/`fall` during cycle k+2.
- **Result latency:** outputs and `valid` are registered, visible the cycle after the terminating `rise` is detected.
- **`start` to ARM:** ARM is entered the cycle after `start`. An edge detected in that same cycle is ignored.
- **Minimum widths:** high and low widths of 1 cycle are measured correctly (result 1). Pulses narrower than one `clk_in` period may be missed.
- **Back-to-back:** `valid` and a new `start` may occur in the same cycle. The new `start` is accepted, because the FSM is in IDLE that cycle.

## Configuration
- **`PULSE_METER_CONT_EN` undefined:** one-shot. Each `start` yields exactly one measurement, then IDLE.
- **`PULSE_METER_CONT_EN` defined:** continuous mode.
  - The terminating `rise` in LOW also serves as t0 of the next measurement: `cnt` reloads to 1 and the FSM goes directly to HIGH.
  - `busy` stays high and `valid` fires once per period.
  - `start` is still required once after reset. `err` returns to IDLE in both modes.

## Test plan
- **1/99 pulse:** `sig_in` high 1 cycle, low 99, repeating; `start` once. Expect `high_cnt=1`, `low_cnt=99`, `period=100`, one `valid`, `busy` then 0.
- **Square wave:** `sig_in` high 100, low 100; `start` while `sig_in` already high. Expect the first partial high ignored, then `high_cnt=100`, `low_cnt=100`, `period=200`.
- **Overflow:** `CNT_W=4`, `sig_in` held high after a rise. Expect `err` pulse when `cnt` reaches 15, no `valid`, outputs unchanged, `busy=0`.
- **Reset mid-measurement:** drop `rst_n` during LOW. Expect all outputs 0 immediately; after release, no `valid` without a new `start`.
- **Ignored start:** `start` pulsed during HIGH. Expect no restart and the result unchanged versus the undisturbed run (3/5 → 3, 5, 8).
- **Continuous mode:** `PULSE_METER_CONT_EN` defined, 3 high / 5 low. Expect `valid` every 8 cycles with 3/5/8 each time, `busy` constantly 1.
